cla_nibble_serial_adder: RTL and testbench

- Multi-cycle WIDTH-bit add/subtract unit built around a single 4-bit carry-lookahead adder slice.
- The controller sequences that one slice over the operand nibbles, least significant first, one nibble per clock.
- Carry is held in a register between nibbles.
- It is the team's area-lean wide adder: one CLA slice is reused instead of instantiating WIDTH/4 slices.

---
 rtl/cla_nibble_serial_adder.sv | 144 ++++++++++++++
 tb/tb_cla_nibble_serial_adder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cla_nibble_serial_adder.sv
// cla_nibble_serial_adder: WIDTH-bit add/subtract built from one 4-bit
// carry-lookahead slice, stepped over the operand nibbles LSB first.
// The carry between nibbles lives in r_carry; subtract is a + ~b + 1.
module cla_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB  = WIDTH / 4;
  // Wide enough to hold NIB, the value the index reaches after the last step.
  localparam int IDXW = $clog2(NIB + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // 4-bit carry-lookahead slice.
  // Returns {carry out of bit 3, carry into bit 3, sum[3:0]}.
  function automatic logic [5:0] cla4(input logic [3:0] x,
                                      input logic [3:0] y,
                                      input logic       ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], c[3], p ^ c[3:0]};
  endfunction

  state_t            r_state;
  state_t            w_next;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_sum;
  logic              r_carry;
  logic              r_cout;
  logic              r_ovf;
  logic [IDXW-1:0]   r_idx;

  logic              w_accept;
  logic              w_last;
  logic [3:0]        w_a_nib;
  logic [3:0]        w_b_nib;
  logic [5:0]        w_slice;

  // Start is only honoured when no operation is in flight.
  assign w_accept = start & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_last   = (r_idx == LAST_IDX);

  // Current nibble of each captured operand.
  assign w_a_nib = 4'(r_a >> {r_idx, 2'b00});
  assign w_b_nib = 4'(r_b >> {r_idx, 2'b00});
  assign w_slice = cla4(w_a_nib, w_b_nib, r_carry);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_RUN;
        else       w_next = S_IDLE;
      end
      S_RUN: begin
        if (w_last) w_next = S_DONE;
        else        w_next = S_RUN;
      end
      S_DONE: begin
        if (start) w_next = S_RUN;
        else       w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: capture operands on accept, then fold one nibble per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == S_RUN) begin
      for (int k = 0; k < NIB; k++) begin
        if (r_idx == IDXW'(k)) begin
          r_sum[4*k +: 4] <= w_slice[3:0];
        end
      end
      r_carry <= w_slice[5];
      r_idx   <= r_idx + 1'b1;
      if (w_last) begin
        r_cout <= w_slice[5];
        r_ovf  <= w_slice[5] ^ w_slice[4];
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Self-checking bench for cla_nibble_serial_adder (WIDTH=16 and WIDTH=4).
module tb_cla_nibble_serial_adder;

  logic        clk;
  logic        rst;
  logic        start16, sub16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;
  logic        start4, sub4, busy4, done4, cout4, ovf4;
  logic [3:0]  a4, b4, sum4;

  int total = 0;
  int bad   = 0;

  cla_nibble_serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  cla_nibble_serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic plus sign-rule overflow.
  task automatic ref_op(input int w, input longint unsigned x,
                        input longint unsigned y, input bit s,
                        output longint unsigned r, output bit co,
                        output bit ov);
    longint unsigned md, msb, full;
    bit sx, sy, sr;
    md  = 64'd1 << w;
    msb = 64'd1 << (w - 1);
    if (s) begin
      full = x - y;
      co   = (x >= y);
    end else begin
      full = x + y;
      co   = (full >= md);
    end
    r  = full & (md - 64'd1);
    sx = (x & msb) != 64'd0;
    sy = (y & msb) != 64'd0;
    sr = (r & msb) != 64'd0;
    if (s) ov = (sx != sy) && (sr != sx);
    else   ov = (sx == sy) && (sr != sx);
  endtask

  // Start a 16-bit op from an IDLE or DONE cycle and follow it to DONE.
  // glitch_at: RUN step at which a conflicting start is pulsed (-1 = none).
  task automatic do_op16(input logic [15:0] xa, input logic [15:0] xb,
                         input logic xs, input int glitch_at);
    longint unsigned r;
    bit co, ov;
    ref_op(16, 64'(xa), 64'(xb), xs, r, co, ov);
    a16 = xa; b16 = xb; sub16 = xs; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    a16 = 16'($urandom);
    b16 = 16'($urandom);
    sub16 = 1'($urandom);
    for (int k = 0; k < 4; k++) begin
      check("run_busy", 64'(busy16), 64'd1);
      check("run_done", 64'(done16), 64'd0);
      check("run_partial", 64'(sum16), r & ((64'd1 << (4 * k)) - 64'd1));
      check("run_cout", 64'(cout16), 64'd0);
      check("run_ovf", 64'(ovf16), 64'd0);
      if (k == glitch_at) begin
        start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; sub16 = 1'b1;
      end
      tick();
      start16 = 1'b0;
    end
    check("done_busy", 64'(busy16), 64'd0);
    check("done_pulse", 64'(done16), 64'd1);
    check("sum", 64'(sum16), r);
    check("cout", 64'(cout16), 64'(co));
    check("ovf", 64'(ovf16), 64'(ov));
  endtask

  // Start a 4-bit op (single RUN cycle) and follow it to DONE.
  task automatic do_op4(input logic [3:0] xa, input logic [3:0] xb,
                        input logic xs);
    longint unsigned r;
    bit co, ov;
    ref_op(4, 64'(xa), 64'(xb), xs, r, co, ov);
    a4 = xa; b4 = xb; sub4 = xs; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check("w4_busy", 64'(busy4), 64'd1);
    check("w4_run_done", 64'(done4), 64'd0);
    tick();
    check("w4_done_busy", 64'(busy4), 64'd0);
    check("w4_done", 64'(done4), 64'd1);
    check("w4_sum", 64'(sum4), r);
    check("w4_cout", 64'(cout4), 64'(co));
    check("w4_ovf", 64'(ovf4), 64'(ov));
  endtask

  initial begin
    bit saw_done;
    logic [15:0] held;
    rst = 1'b1;
    start16 = 1'b0; sub16 = 1'b0; a16 = 16'd0; b16 = 16'd0;
    start4 = 1'b0;  sub4 = 1'b0;  a4 = 4'd0;   b4 = 4'd0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_busy", 64'(busy16), 64'd0);
    check("rst_done", 64'(done16), 64'd0);
    check("rst_sum", 64'(sum16), 64'd0);
    check("rst_cout", 64'(cout16), 64'd0);
    check("rst_ovf", 64'(ovf16), 64'd0);
    check("rst4_sum", 64'(sum4), 64'd0);
    tick();

    // Directed arithmetic cases
    do_op16(16'h1234, 16'h4321, 1'b0, -1);
    tick();
    do_op16(16'hFFFF, 16'h0001, 1'b0, -1);
    tick();
    do_op16(16'h7FFF, 16'h0001, 1'b0, -1);
    tick();
    do_op16(16'h0005, 16'h0007, 1'b1, -1);
    tick();
    do_op16(16'h8000, 16'h0001, 1'b1, -1);
    held = sum16;
    tick();
    tick();
    tick();
    check("idle_hold_sum", 64'(sum16), 64'(held));
    check("idle_busy", 64'(busy16), 64'd0);
    check("idle_done", 64'(done16), 64'd0);

    // Start during RUN is ignored; back-to-back start in DONE is accepted
    do_op16(16'h1111, 16'h2222, 1'b0, 1);
    do_op16(16'hABCD, 16'h1234, 1'b1, -1);
    tick();

    // Reset in the third RUN cycle aborts without a done pulse
    a16 = 16'h1234; b16 = 16'h1111; sub16 = 1'b0; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 64'(busy16), 64'd0);
    check("abort_done", 64'(done16), 64'd0);
    check("abort_sum", 64'(sum16), 64'd0);
    check("abort_cout", 64'(cout16), 64'd0);
    check("abort_ovf", 64'(ovf16), 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done16 !== 1'b0 || busy16 !== 1'b0) saw_done = 1'b1;
      tick();
    end
    check("abort_quiet", 64'(saw_done), 64'd0);
    do_op16(16'h0F0F, 16'h00F1, 1'b0, -1);
    tick();

    // Randomised 16-bit ops, mixing idle gaps and back-to-back starts
    for (int i = 0; i < 24; i++) begin
      do_op16(16'($urandom), 16'($urandom), 1'($urandom), -1);
      if ($urandom_range(1, 0) == 0) tick();
    end
    tick();

    // WIDTH=4: single-step operation
    do_op4(4'h9, 4'h8, 1'b0);
    tick();
    for (int i = 0; i < 16; i++) begin
      do_op4(4'($urandom), 4'($urandom), 1'($urandom));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
